// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads program RAM (1-cycle latency) and hands instructions to decode.
// Optional FETCH_STALL_CNT_EN adds o_stall_cnt, a saturating count of RUN cycles stalled by the decoder.
`timescale 1ns/1ps
module instr_fetch #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pc_recount,
    input  logic              i_jump_en,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid,
    input  logic              i_instr_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_epoch;
    logic                r_inflight;
    logic                r_inflight_epoch;
    logic [ADDR_W-1:0]   r_inflight_pc;
    logic [DATA_W-1:0]   r_fifo_instr [2];
    logic [ADDR_W-1:0]   r_fifo_pc    [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    logic                w_run;
    logic [1:0]          w_occ;
    logic                w_issue;
    logic                w_land;
    logic                w_fifo_empty;
    logic                w_head_valid;
    logic                w_xfer;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;

    always_comb begin
        w_state_next  = r_state;
        w_run         = (r_state == S_RUN);
        w_occ         = r_count + {1'b0, r_inflight};
        w_issue       = w_run && (w_occ < 2'd2);
        // A returning read counts only if no flush happened since it was issued.
        w_land        = w_run && r_inflight && (r_inflight_epoch == r_epoch);
        w_fifo_empty  = (r_count == 2'd0);
        w_head_valid  = w_run && (!w_fifo_empty || w_land);
        w_xfer        = w_head_valid && i_instr_ready;
        w_flush       = i_pc_recount || (w_run && i_jump_en);
        w_pop         = w_xfer && !w_fifo_empty;
        w_push        = w_land && !(w_fifo_empty && w_xfer);
        o_ram_re      = w_issue;
        o_ram_addr    = w_issue ? r_pc : '0;
        o_instr_valid = w_head_valid;
        o_instr       = '0;
        o_instr_pc    = '0;
        // Empty FIFO: landing RAM data bypasses straight to the decoder.
        if (!w_fifo_empty) begin
            o_instr    = r_fifo_instr[r_rd_ptr];
            o_instr_pc = r_fifo_pc[r_rd_ptr];
        end else if (w_land) begin
            o_instr    = i_ram_rdata;
            o_instr_pc = r_inflight_pc;
        end
        if (i_pc_recount) begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_pc             <= '0;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= '0;
            r_rd_ptr         <= 1'b0;
            r_wr_ptr         <= 1'b0;
            r_count          <= 2'd0;
        end else begin
            r_state          <= w_state_next;
            r_inflight       <= w_issue;
            r_inflight_epoch <= r_epoch;
            r_inflight_pc    <= r_pc;
            if (w_flush) begin
                r_epoch  <= ~r_epoch;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
            if (i_pc_recount) begin
                r_pc <= '0;
            end else if (w_run && i_jump_en) begin
                r_pc <= i_jump_addr;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // Storage needs no reset; r_count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (!w_flush && w_push) begin
            r_fifo_instr[r_wr_ptr] <= i_ram_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_pc_recount) begin
            r_stall_cnt <= '0;
        end else if (w_head_valid && !i_instr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
